// File: rtl/bpu_gshare_tagged_pkg.sv
// Shared types and helpers for bpu_gshare_tagged: branch type encoding,
// BTB entry layout and PC field extraction (index / tag).
package bpu_pkg;

  localparam int PKG_XLEN     = 32;
  localparam int PKG_TAG_BITS = 8;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  // Target is stored word-aligned; the two low PC bits are implied zero.
  typedef struct packed {
    logic                    valid;
    logic [PKG_TAG_BITS-1:0] tag;
    br_type_e                br_type;
    logic [PKG_XLEN-3:0]     target;
  } btb_entry_t;

  // pc[bits+1:2], zero-extended; callers size-cast to the table index width.
  function automatic logic [PKG_XLEN-1:0] pc_index(input logic [PKG_XLEN-1:0] pc,
                                                   input int bits);
    return (pc >> 2) & ((PKG_XLEN'(1) << bits) - PKG_XLEN'(1));
  endfunction

  // pc[idx_bits+tag_bits+1 : idx_bits+2], zero-extended.
  function automatic logic [PKG_XLEN-1:0] pc_tag(input logic [PKG_XLEN-1:0] pc,
                                                 input int idx_bits,
                                                 input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((PKG_XLEN'(1) << tag_bits) - PKG_XLEN'(1));
  endfunction

endpackage

// File: rtl/bpu_gshare_tagged_if.sv
// Fetch lookup and commit update bundle of bpu_gshare_tagged.
// master: fetch/commit side, slave: the predictor.
interface bpu_gshare_tagged_if #(
  parameter int XLEN = 32,
  parameter int G    = 8
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [G-1:0]    pred_index;
  logic [G-1:0]    pred_ghr;
  logic            u_valid;
  logic [XLEN-1:0] u_pc;
  logic [1:0]      u_type;
  logic            u_taken;
  logic [XLEN-1:0] u_target;
  logic [G-1:0]    u_index;
  logic [G-1:0]    u_ghr;
  logic            u_mispredict;

  modport master (
    output f_valid, f_pc, u_valid, u_pc, u_type, u_taken, u_target,
           u_index, u_ghr, u_mispredict,
    input  pred_taken, pred_target, pred_index, pred_ghr
  );

  modport slave (
    input  f_valid, f_pc, u_valid, u_pc, u_type, u_taken, u_target,
           u_index, u_ghr, u_mispredict,
    output pred_taken, pred_target, pred_index, pred_ghr
  );
endinterface

// File: rtl/bpu_gshare_tagged_ras.sv
// bpu_ras: circular return address stack. When full, a push overwrites the
// oldest entry and the count stays at DEPTH. Popping an empty stack is ignored.
module bpu_ras #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   count;

  // Pointer and occupancy; flush empties the stack.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop && count != '0) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  // Entry storage is not reset; the count gates whether top is meaningful.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[ptr] <= push_data;
  end

  assign top   = mem[ptr - PW'(1)];
  assign empty = (count == '0);
endmodule

// File: rtl/bpu_gshare_tagged.sv
// bpu_gshare_tagged: gshare PHT + tagged direct-mapped BTB + speculative GHR.
// Lookup is combinational from f_pc; training happens on commit.
// Optional feature: define RAS_EN to add the return address stack (bpu_ras).
module bpu_gshare_tagged
  import bpu_pkg::*;
#(
  parameter int XLEN      = PKG_XLEN,
  parameter int PHT_DEPTH = 256,
  parameter int CTR_BITS  = 2,
  parameter int BTB_DEPTH = 64,
  parameter int TAG_BITS  = PKG_TAG_BITS,
  parameter int RAS_DEPTH = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic flush,
  bpu_gshare_tagged_if.slave bus
);
  localparam int G  = $clog2(PHT_DEPTH);
  localparam int BI = $clog2(BTB_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [G-1:0]        ghr;
  logic [CTR_BITS-1:0] pht [PHT_DEPTH];
  btb_entry_t          btb [BTB_DEPTH];

  logic [BI-1:0]       f_bi, u_bi;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  btb_entry_t          f_ent;
  br_type_e            u_br;
  logic                hit, ctr_msb, ras_hit;
  logic [XLEN-1:0]     seq_pc, ras_top;

  assign f_bi  = BI'(pc_index(bus.f_pc, BI));
  assign f_tag = TAG_BITS'(pc_tag(bus.f_pc, BI, TAG_BITS));
  assign u_bi  = BI'(pc_index(bus.u_pc, BI));
  assign u_tag = TAG_BITS'(pc_tag(bus.u_pc, BI, TAG_BITS));
  assign u_br  = br_type_e'(bus.u_type);

  assign f_ent   = btb[f_bi];
  assign hit     = f_ent.valid && (f_ent.tag == f_tag);
  assign ctr_msb = pht[bus.pred_index][CTR_BITS-1];
  assign seq_pc  = bus.f_pc + XLEN'(4);

  assign bus.pred_index  = G'(pc_index(bus.f_pc, G)) ^ ghr;
  assign bus.pred_ghr    = ghr;
  assign bus.pred_taken  = hit && ((f_ent.br_type != BR_COND) || ctr_msb);
  assign bus.pred_target = ras_hit        ? ras_top :
                           bus.pred_taken ? {f_ent.target, 2'b00} : seq_pc;

`ifdef RAS_EN
  logic ras_empty, ras_push, ras_pop;

  assign ras_push = bus.f_valid && hit && (f_ent.br_type == BR_CALL);
  assign ras_pop  = bus.f_valid && hit && (f_ent.br_type == BR_RET) && !ras_empty;
  assign ras_hit  = hit && (f_ent.br_type == BR_RET) && !ras_empty;

  bpu_ras #(.DEPTH(RAS_DEPTH), .W(XLEN)) u_ras (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif

  // GHR: flush, then mispredict restore, then speculative shift on a cond hit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ghr <= '0;
    end else if (flush) begin
      ghr <= '0;
    end else if (bus.u_valid && bus.u_mispredict) begin
      ghr <= (u_br == BR_COND) ? {bus.u_ghr[G-2:0], bus.u_taken} : bus.u_ghr;
    end else if (bus.f_valid && hit && (f_ent.br_type == BR_COND)) begin
      ghr <= {ghr[G-2:0], ctr_msb};
    end
  end

  // PHT training: saturating counters, conditional branches only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CTR_INIT;
    end else if (bus.u_valid && (u_br == BR_COND)) begin
      if (bus.u_taken && (pht[bus.u_index] != CTR_MAX))
        pht[bus.u_index] <= pht[bus.u_index] + CTR_BITS'(1);
      else if (!bus.u_taken && (pht[bus.u_index] != '0))
        pht[bus.u_index] <= pht[bus.u_index] - CTR_BITS'(1);
    end
  end

  // BTB allocation on every taken commit; not-taken branches never allocate.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb[i] <= '0;
    end else if (bus.u_valid && bus.u_taken) begin
      btb[u_bi] <= '{valid: 1'b1, tag: u_tag, br_type: u_br,
                     target: bus.u_target[XLEN-1:2]};
    end
  end
endmodule

// File: tb/tb_bpu_gshare_tagged.sv
// Testbench for bpu_gshare_tagged: directed steps followed by a random phase,
// all checked against an arithmetic reference model of the predictor.
module tb_bpu_gshare_tagged;
  localparam int XLEN = 32;
  localparam int PD   = 256;
  localparam int G    = 8;
  localparam int CB   = 2;
  localparam int BD   = 64;
  localparam int TB   = 8;
  localparam int RD   = 8;
  localparam int CMAX = (1 << CB) - 1;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic flush  = 1'b0;

  bpu_gshare_tagged_if #(.XLEN(XLEN), .G(G)) bus ();

  bpu_gshare_tagged #(
    .XLEN(XLEN), .PHT_DEPTH(PD), .CTR_BITS(CB),
    .BTB_DEPTH(BD), .TAG_BITS(TB), .RAS_DEPTH(RD)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // reference model state
  int          ghr_m;
  int          ctr_m  [PD];
  bit          bv_m   [BD];
  int          btag_m [BD];
  int          btyp_m [BD];
  bit [31:0]   btgt_m [BD];
  bit [31:0]   ras_q  [$];
  bit          ras_en;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_reset();
    ghr_m = 0;
    for (int i = 0; i < PD; i++) ctr_m[i] = 1 << (CB - 1);
    for (int i = 0; i < BD; i++) begin
      bv_m[i] = 1'b0; btag_m[i] = 0; btyp_m[i] = 0; btgt_m[i] = '0;
    end
    ras_q.delete();
  endtask

  function automatic void model_lookup(input bit [31:0] pc, output bit hit,
                                       output int typ, output bit msb,
                                       output bit taken, output bit [31:0] tgt,
                                       output int idx);
    int bi;
    int tg;
    bi    = int'((pc / 4) % BD);
    tg    = int'((pc / (4 * BD)) % (1 << TB));
    hit   = bv_m[bi] && (btag_m[bi] == tg);
    typ   = btyp_m[bi];
    idx   = int'((pc / 4) % PD) ^ ghr_m;
    msb   = ctr_m[idx] >= (1 << (CB - 1));
    taken = hit && (typ != 0 || msb);
    if (hit && typ == 3 && ras_en && ras_q.size() > 0) tgt = ras_q[$];
    else if (taken) tgt = btgt_m[bi];
    else tgt = pc + 32'd4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // compare all prediction outputs with the model, mid-cycle
  task automatic check_pred(input string tag);
    bit hit, msb, taken;
    int typ, idx;
    bit [31:0] tgt;
    @(negedge clock);
    model_lookup(bus.f_pc, hit, typ, msb, taken, tgt, idx);
    check({tag, ".taken"},  32'(bus.pred_taken), 32'(taken));
    check({tag, ".target"}, bus.pred_target,     tgt);
    check({tag, ".index"},  32'(bus.pred_index), 32'(idx));
    check({tag, ".ghr"},    32'(bus.pred_ghr),   32'(ghr_m));
  endtask

  // advance the model by one clock using the current inputs, then clock the DUT
  task automatic step();
    bit hit, msb, taken;
    int typ, idx, bi;
    bit [31:0] tgt;
    model_lookup(bus.f_pc, hit, typ, msb, taken, tgt, idx);
    if (flush) ghr_m = 0;
    else if (bus.u_valid && bus.u_mispredict)
      ghr_m = (bus.u_type == 2'd0) ? ((int'(bus.u_ghr) * 2 + int'(bus.u_taken)) % PD)
                                   : int'(bus.u_ghr);
    else if (bus.f_valid && hit && typ == 0)
      ghr_m = (ghr_m * 2 + int'(msb)) % PD;
    if (bus.u_valid && bus.u_type == 2'd0) begin
      if (bus.u_taken) begin
        if (ctr_m[bus.u_index] < CMAX) ctr_m[bus.u_index]++;
      end else if (ctr_m[bus.u_index] > 0) ctr_m[bus.u_index]--;
    end
    if (bus.u_valid && bus.u_taken) begin
      bi         = int'((bus.u_pc / 4) % BD);
      bv_m[bi]   = 1'b1;
      btag_m[bi] = int'((bus.u_pc / (4 * BD)) % (1 << TB));
      btyp_m[bi] = int'(bus.u_type);
      btgt_m[bi] = bus.u_target & 32'hFFFF_FFFC;
    end
    if (ras_en) begin
      if (flush) ras_q.delete();
      else if (bus.f_valid && hit && typ == 2) begin
        ras_q.push_back(bus.f_pc + 32'd4);
        if (ras_q.size() > RD) void'(ras_q.pop_front());
      end else if (bus.f_valid && hit && typ == 3 && ras_q.size() > 0)
        void'(ras_q.pop_back());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    bus.f_valid = 1'b0; bus.f_pc = '0;
    bus.u_valid = 1'b0; bus.u_pc = '0; bus.u_type = 2'd0; bus.u_taken = 1'b0;
    bus.u_target = '0; bus.u_index = '0; bus.u_ghr = '0; bus.u_mispredict = 1'b0;
  endtask

  task automatic commit(input bit [31:0] pc, input bit [1:0] typ, input bit taken,
                        input bit [31:0] target, input bit [7:0] idx);
    bus.u_valid = 1'b1; bus.u_pc = pc; bus.u_type = typ; bus.u_taken = taken;
    bus.u_target = target; bus.u_index = idx; bus.u_ghr = '0; bus.u_mispredict = 1'b0;
    step();
    bus.u_valid = 1'b0;
  endtask

  function automatic bit [31:0] rnd_pc();
    bit [31:0] p;
    p = 32'h1000 + 32'(4 * $urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) p = p + 32'(4 * BD);
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ras_en = 1'b0;
`ifdef RAS_EN
    ras_en = 1'b1;
`endif
    idle();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;

    // reset state
    bus.f_pc = 32'h100;
    check_pred("rst");
    check("rst_taken_c",  32'(bus.pred_taken), 32'd0);
    check("rst_target_c", bus.pred_target,     32'h104);
    check("rst_ghr_c",    32'(bus.pred_ghr),   32'd0);
    step();

    // BTB allocation, tag compare
    commit(32'h200, 2'd0, 1'b1, 32'h300, 8'h80);
    bus.f_pc = 32'h200;
    check_pred("hit");
    check("hit_taken_c",  32'(bus.pred_taken), 32'd1);
    check("hit_target_c", bus.pred_target,     32'h300);
    bus.f_pc = 32'h200 + 32'(BD * 4);
    check_pred("alias");
    check("alias_taken_c", 32'(bus.pred_taken), 32'd0);
    step();

    // counter saturation at both ends
    repeat (4) commit(32'h200, 2'd0, 1'b0, 32'h0, 8'h80);
    bus.f_pc = 32'h200;
    check_pred("ctr0");
    check("ctr0_taken_c", 32'(bus.pred_taken), 32'd0);
    commit(32'h200, 2'd0, 1'b0, 32'h0, 8'h80);
    commit(32'h200, 2'd0, 1'b1, 32'h300, 8'h80);
    check_pred("ctr1");
    check("ctr_sat0_taken_c", 32'(bus.pred_taken), 32'd0);
    repeat (3) commit(32'h200, 2'd0, 1'b1, 32'h300, 8'h80);
    check_pred("ctr3");
    check("ctr3_taken_c", 32'(bus.pred_taken), 32'd1);
    commit(32'h200, 2'd0, 1'b0, 32'h0, 8'h80);
    check_pred("ctr_sat3");
    check("ctr_sat3_taken_c", 32'(bus.pred_taken), 32'd1);

    // speculative GHR and mispredict restore vs same-cycle fetch hit
    bus.f_valid = 1'b1; bus.f_pc = 32'h200;
    step();
    check_pred("spec1");
    step();
    check_pred("spec2");
    check("spec_ghr_c", 32'(bus.pred_ghr), 32'd3);
    bus.u_valid = 1'b1; bus.u_mispredict = 1'b1; bus.u_type = 2'd0; bus.u_taken = 1'b0;
    bus.u_ghr = '0; bus.u_index = 8'h10; bus.u_pc = 32'h200;
    step();
    idle();
    bus.f_pc = 32'h200;
    check_pred("restore");
    check("restore_ghr_c", 32'(bus.pred_ghr), 32'd0);

    // flush beats a fetch hit
    bus.f_valid = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; bus.f_valid = 1'b0;
    check_pred("flush");
    check("flush_ghr_c", 32'(bus.pred_ghr), 32'd0);

    // sequential PC wraps
    bus.f_pc = 32'hFFFF_FFFC;
    check_pred("wrap");
    check("wrap_target_c", bus.pred_target, 32'h0);

    // asynchronous reset mid-run
    bus.f_valid = 1'b1; bus.f_pc = 32'h200;
    step();
    bus.f_valid = 1'b0;
    #2 resetn = 1'b0;
    model_reset();
    check_pred("midrst");
    check("midrst_ghr_c",   32'(bus.pred_ghr),   32'd0);
    check("midrst_taken_c", 32'(bus.pred_taken), 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // calls / returns (RAS when built with it, BTB target otherwise)
    commit(32'h400, 2'd2, 1'b1, 32'h800, 8'h00);
    commit(32'h5F0, 2'd3, 1'b1, 32'h900, 8'h00);
    for (int k = 0; k <= RD; k++) commit(32'h704 + 32'(4 * k), 2'd2, 1'b1, 32'hA00, 8'h00);
    bus.f_valid = 1'b1; bus.f_pc = 32'h400;
    step();
    bus.f_pc = 32'h5F0;
    check_pred("ret1");
    check("ret1_target_c", bus.pred_target, ras_en ? 32'h404 : 32'h900);
    step();
    for (int k = 0; k <= RD; k++) begin
      bus.f_pc = 32'h704 + 32'(4 * k);
      step();
    end
    for (int j = 0; j < RD; j++) begin
      bus.f_pc = 32'h5F0;
      check_pred("ret_lifo");
      check("ret_lifo_c", bus.pred_target, ras_en ? (32'h708 + 32'(4 * (RD - j))) : 32'h900);
      step();
    end
    check_pred("ret_empty");
    check("ret_empty_c", bus.pred_target, 32'h900);
    bus.f_pc = 32'h704;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; bus.f_valid = 1'b0; bus.f_pc = 32'h5F0;
    check_pred("ret_flush");
    check("ret_flush_c", bus.pred_target, 32'h900);
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.f_valid      = ($urandom_range(0, 9) < 7);
      bus.f_pc         = rnd_pc();
      bus.u_valid      = 1'($urandom_range(0, 1));
      bus.u_pc         = rnd_pc();
      bus.u_type       = 2'($urandom_range(0, 3));
      bus.u_taken      = 1'($urandom_range(0, 1));
      bus.u_target     = $urandom & 32'hFFFF_FFFC;
      bus.u_index      = 8'($urandom_range(0, PD - 1));
      bus.u_ghr        = 8'($urandom_range(0, PD - 1));
      bus.u_mispredict = ($urandom_range(0, 9) == 0);
      flush            = ($urandom_range(0, 29) == 0);
      check_pred("rnd");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
